// File: rtl/stream_arb2_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb2_pkg
// Shared types and constants for the two-input round-robin stream arbiter.
//   out_state_t : output register occupancy (EMPTY / FULL)
//   PRIO_A/B    : encoding of the one-bit priority register
//   CNT_W/MAX   : width and saturation value of the optional grant counters
//                 (only used when STREAM_ARB2_CNT_EN is defined)
// -----------------------------------------------------------------------------
package stream_arb2_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    localparam logic        PRIO_A  = 1'b0;
    localparam logic        PRIO_B  = 1'b1;
    localparam int unsigned CNT_W   = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage : stream_arb2_pkg

// File: rtl/stream_arb2_rr_grant2.sv
// -----------------------------------------------------------------------------
// rr_grant2
// Purely combinational two-requester grant with a one-bit priority input.
// Ports:
//   req_i[1:0] : request vector, bit 0 = A, bit 1 = B
//   prio_i     : PRIO_A (0) prefers A, PRIO_B (1) prefers B on contention
//   gnt_o[1:0] : one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_grant2
    import stream_arb2_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (prio_i == PRIO_A) ? 2'b01 : 2'b10;
        end
    end

endmodule : rr_grant2

// File: rtl/stream_arb2.sv
// -----------------------------------------------------------------------------
// stream_arb2
// Two-input round-robin stream arbiter with a single registered output stage.
// The registered sel tag follows the downstream 2:1 mux convention:
// sel = 1 selects A, sel = 0 selects B.
//
// Optional feature: define STREAM_ARB2_CNT_EN to add saturating 16-bit grant
// counters cnt_a / cnt_b.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. Ready may depend on valid (a_ready looks at
// b_valid for arbitration); valid must never depend on ready.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   a_valid/a_data/a_ready: producer A stream
//   b_valid/b_data/b_ready: producer B stream
//   out_valid/out_data    : registered output beat
//   out_ready             : consumer ready
//   sel                   : registered source tag of out_data (1 = A, 0 = B)
//   cnt_a, cnt_b          : grant counters (STREAM_ARB2_CNT_EN only)
//   dbg_state_o           : output FSM state, for checkers
//   dbg_prio_o            : priority register, for checkers
// -----------------------------------------------------------------------------
module stream_arb2
    import stream_arb2_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,

    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,

    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              sel,

`ifdef STREAM_ARB2_CNT_EN
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b,
`endif

    output out_state_t        dbg_state_o,
    output logic              dbg_prio_o
);

    out_state_t        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sel_q, sel_d;
    logic              prio_q, prio_d;

    logic              load_en;
    logic [1:0]        gnt;
    logic              accept_a;
    logic              accept_b;

    // Stage can take a beat when empty, or when full and draining this edge.
    assign load_en = (state_q == EMPTY) || out_ready;

    rr_grant2 u_grant (
        .req_i  ({b_valid, a_valid}),
        .prio_i (prio_q),
        .gnt_o  (gnt)
    );

    // Readies are forced low during reset so no beat is lost to the reset edge.
    assign a_ready  = load_en && gnt[0] && !rst;
    assign b_ready  = load_en && gnt[1] && !rst;
    assign accept_a = a_valid && a_ready;
    assign accept_b = b_valid && b_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        if (accept_a) begin
            state_d = FULL;
            data_d  = a_data;
            sel_d   = 1'b1;
            prio_d  = PRIO_B;
        end else if (accept_b) begin
            state_d = FULL;
            data_d  = b_data;
            sel_d   = 1'b0;
            prio_d  = PRIO_A;
        end else if (state_q == FULL && out_ready) begin
            // Drain without refill: data and sel keep their last value.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 1'b0;
            prio_q  <= PRIO_A;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
        end
    end

    assign out_valid   = (state_q == FULL);
    assign out_data    = data_q;
    assign sel         = sel_q;
    assign dbg_state_o = state_q;
    assign dbg_prio_o  = prio_q;

`ifdef STREAM_ARB2_CNT_EN
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    // Saturating increment: the counters stick at CNT_MAX instead of wrapping.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (accept_a && cnt_a_q != CNT_MAX) begin
            cnt_a_d = cnt_a_q + 1'b1;
        end
        if (accept_b && cnt_b_q != CNT_MAX) begin
            cnt_b_d = cnt_b_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule : stream_arb2

// File: tb/tb_stream_arb2.sv
// -----------------------------------------------------------------------------
// tb_stream_arb2
// Directed testbench for stream_arb2. Inputs are driven 1 ns after the rising
// edge; readies are checked before the next edge and registered outputs 1 ns
// after it. Counter checks are included when STREAM_ARB2_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_stream_arb2;
    import stream_arb2_pkg::*;

    localparam int DATA_W = 8;

    logic              clk;
    logic              rst;
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              sel;
    out_state_t        dbg_state;
    logic              dbg_prio;
`ifdef STREAM_ARB2_CNT_EN
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    stream_arb2 #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .sel         (sel),
`ifdef STREAM_ARB2_CNT_EN
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b),
`endif
        .dbg_state_o (dbg_state),
        .dbg_prio_o  (dbg_prio)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [7:0] ad,
                         input logic bv, input logic [7:0] bd, input logic ordy);
        a_valid   = av;
        a_data    = ad;
        b_valid   = bv;
        b_data    = bd;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        step();
        step();
        rst = 1'b0;
    endtask

    // Checks the registered output after an edge.
    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic s);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".out_data"},  32'(out_data),  32'(d));
        check({tag, ".sel"},       32'(sel),       32'(s));
    endtask

    task automatic check_rdy(input string tag, input logic ar, input logic br);
        check({tag, ".a_ready"}, 32'(a_ready), 32'(ar));
        check({tag, ".b_ready"}, 32'(b_ready), 32'(br));
        check({tag, ".one_hot"}, 32'(a_ready & b_ready), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       exp_sel;
        logic [7:0] exp_data;

        do_reset();
        check_out("reset", 1'b0, 8'h00, 1'b0);
        check("reset.prio",  32'(dbg_prio),  32'(PRIO_A));
        check("reset.state", 32'(dbg_state), 32'(EMPTY));

        // Single A beat.
        drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
        #1;
        check_rdy("single_a", 1'b1, 1'b0);
        step();
        check_out("single_a", 1'b1, 8'h11, 1'b1);
        check("single_a.prio",  32'(dbg_prio),  32'(PRIO_B));
        check("single_a.state", 32'(dbg_state), 32'(FULL));

        // Continuous contention: A, B, A, B after reset.
        do_reset();
        drive(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_sel  = (i % 2 == 0);
            exp_data = exp_sel ? 8'hA0 : 8'hB0;
            #1;
            check_rdy($sformatf("alt%0d", i), exp_sel, !exp_sel);
            step();
            check_out($sformatf("alt%0d", i), 1'b1, exp_data, exp_sel);
        end
        check("alt.prio", 32'(dbg_prio), 32'(PRIO_A));

        // Backpressure: full, consumer stalled, both valid.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_rdy($sformatf("stall%0d", i), 1'b0, 1'b0);
            step();
            check_out($sformatf("stall%0d", i), 1'b1, 8'hB0, 1'b0);
        end
        // Release: preferred A refills at the drain edge, no bubble.
        out_ready = 1'b1;
        #1;
        check_rdy("release", 1'b1, 1'b0);
        step();
        check_out("release", 1'b1, 8'hA0, 1'b1);
        check("release.prio", 32'(dbg_prio), 32'(PRIO_B));

        // Reset while FULL with B preferred; readies must be low in reset cycle.
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        check_rdy("rst_mid", 1'b0, 1'b0);
        step();
        check_out("rst_mid", 1'b0, 8'h00, 1'b0);
        check("rst_mid.prio", 32'(dbg_prio), 32'(PRIO_A));
        rst = 1'b0;
        #1;
        check_rdy("post_rst", 1'b1, 1'b0);
        step();
        check_out("post_rst", 1'b1, 8'hA0, 1'b1);

        // Only B valid, three beats.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'(i), 1'b1);
            #1;
            check_rdy($sformatf("only_b%0d", i), 1'b0, 1'b1);
            step();
            check_out($sformatf("only_b%0d", i), 1'b1, 8'(i), 1'b0);
        end
        check("only_b.prio", 32'(dbg_prio), 32'(PRIO_A));

        // Drain with nothing to refill: data and sel hold.
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        check_out("drain", 1'b0, 8'h03, 1'b0);
        check("drain.state", 32'(dbg_state), 32'(EMPTY));

`ifdef STREAM_ARB2_CNT_EN
        do_reset();
        check("cnt.reset_a", 32'(cnt_a), 32'd0);
        check("cnt.reset_b", 32'(cnt_b), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i), 1'b0, 8'h00, 1'b1);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'(i), 1'b1);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        check("cnt.a5", 32'(cnt_a), 32'd5);
        check("cnt.b3", 32'(cnt_b), 32'd3);

        dut.cnt_a_q = 16'hFFFE;
        drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
        step();
        check("cnt.sat1", 32'(cnt_a), 32'hFFFF);
        step();
        step();
        check("cnt.sat3", 32'(cnt_a), 32'hFFFF);
        check("cnt.b_hold", 32'(cnt_b), 32'd3);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_stream_arb2
